// File: rtl/stopwatch_pkg.sv
// Shared constants for the board stopwatch: controller state encoding and BCD digit limits.
package stopwatch_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] LAP   = 2'd3;

  localparam logic [3:0] BCD_NINE  = 4'd9;
  localparam logic [3:0] TENS_FIVE = 4'd5;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter that wraps from LIMIT to 00 and flags the carry on that step.
module bcd_mod60_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out
);

  localparam logic [3:0] LIMIT_TENS = 4'(LIMIT / 10);
  localparam logic [3:0] LIMIT_ONES = 4'(LIMIT % 10);

  logic at_limit;

  assign at_limit  = (tens == LIMIT_TENS) && (ones == LIMIT_ONES);
  assign carry_out = en && at_limit;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (en) begin
      if (at_limit) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == BCD_NINE) begin
        ones <= '0;
        // Tens never exceeds five in a mod-60 field; saturate back to zero defensively.
        tens <= (tens >= TENS_FIVE) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Run/pause/lap/clear sequencer for the stopwatch: button sync, FSM, BCD count and lap snapshot.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SEC_LIMIT   = 59,
  parameter int unsigned MIN_LIMIT   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  // Button bit order everywhere: {clr, ss, lap}.
  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0]                  btn_prev;
  logic [2:0]                  btn_evt;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       sel_clr, sel_ss, sel_lap;
  logic       count_en, clear, snap_load;

  logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
  logic       sec_carry, min_carry;
  logic [7:0] snap_sec, snap_min;
  logic       wrap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= '0;
      btn_prev <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], {btn_clr, btn_ss, btn_lap}};
      btn_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign btn_evt = sync[SYNC_STAGES-1] & ~btn_prev;

  // Only the highest-priority event of a cycle is acted on; the rest are dropped.
  assign sel_clr = btn_evt[2];
  assign sel_ss  = btn_evt[1] && !btn_evt[2];
  assign sel_lap = btn_evt[0] && !btn_evt[1] && !btn_evt[2];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_ss) next_state = RUN;
      RUN:     if (sel_ss) next_state = PAUSE;
               else if (sel_lap) next_state = LAP;
      LAP:     if (sel_ss) next_state = PAUSE;
               else if (sel_lap) next_state = RUN;
      PAUSE:   if (sel_clr) next_state = IDLE;
               else if (sel_ss) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  assign count_en  = tick && (state == RUN || state == LAP);
  assign clear     = sel_clr && (state == PAUSE);
  assign snap_load = sel_lap && (state == RUN);

  bcd_mod60_counter #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .en        (count_en),
    .clr       (clear),
    .tens      (sec_tens),
    .ones      (sec_ones),
    .carry_out (sec_carry)
  );

  bcd_mod60_counter #(.LIMIT(MIN_LIMIT)) u_min (
    .clk       (clk),
    .rst       (rst),
    .en        (sec_carry),
    .clr       (clear),
    .tens      (min_tens),
    .ones      (min_ones),
    .carry_out (min_carry)
  );

  // NOTE: the lap snapshot is reset like any other state register so the display is defined after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      snap_sec   <= '0;
      snap_min   <= '0;
      wrap_d     <= 1'b0;
      wrap       <= 1'b0;
      disp_sec   <= '0;
      disp_min   <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state <= next_state;
      if (clear) begin
        snap_sec <= '0;
        snap_min <= '0;
      end else if (snap_load) begin
        snap_sec <= {sec_tens, sec_ones};
        snap_min <= {min_tens, min_ones};
      end
      // Delayed one stage so the pulse lines up with the 00:00 display.
      wrap_d     <= min_carry && !clear;
      wrap       <= wrap_d;
      disp_sec   <= (state == LAP) ? snap_sec : {sec_tens, sec_ones};
      disp_min   <= (state == LAP) ? snap_min : {min_tens, min_ones};
      running    <= (state == RUN) || (state == LAP);
      lap_active <= (state == LAP);
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed self-checking bench for stopwatch_controller with hand-computed expectations.
module tb_stopwatch_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic [7:0] disp_sec, disp_min;
  logic       running, lap_active, wrap;

  int total = 0;
  int bad   = 0;

  stopwatch_controller #(.SYNC_STAGES(2), .SEC_LIMIT(59), .MIN_LIMIT(59)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .btn_clr    (btn_clr),
    .disp_sec   (disp_sec),
    .disp_min   (disp_min),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // b = {clr, ss, lap}; the press is released and given time to settle.
  task automatic press(input logic [2:0] b, input int hold);
    {btn_clr, btn_ss, btn_lap} = b;
    step(hold);
    {btn_clr, btn_ss, btn_lap} = 3'b000;
    step(4);
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    step(n);
    tick = 1'b0;
    step(2);
  endtask

  task automatic check_disp(input string tag, input logic [7:0] m, input logic [7:0] s);
    check({tag, "_min"}, disp_min, m);
    check({tag, "_sec"}, disp_sec, s);
  endtask

  initial begin
    // Reset state
    step(3);
    check_disp("rst", 8'h00, 8'h00);
    check("rst_running", {7'd0, running}, 8'd0);
    check("rst_lap", {7'd0, lap_active}, 8'd0);
    check("rst_wrap", {7'd0, wrap}, 8'd0);
    #3 rst = 1'b1;
    step(2);

    // Start with a 5-cycle hold, then 3 ticks
    press(3'b010, 5);
    ticks(3);
    check("start_running", {7'd0, running}, 8'd1);
    check_disp("start", 8'h00, 8'h03);

    // Second rollover into minutes
    ticks(56);
    check_disp("pre_min", 8'h00, 8'h59);
    ticks(1);
    check_disp("min_carry", 8'h01, 8'h00);

    // Run to 59:59 then wrap
    ticks(3539);
    check_disp("full", 8'h59, 8'h59);
    check("full_wrap", {7'd0, wrap}, 8'd0);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    check_disp("wrapped", 8'h00, 8'h00);
    check("wrap_pulse", {7'd0, wrap}, 8'd1);
    step(1);
    check("wrap_one_cycle", {7'd0, wrap}, 8'd0);

    // Lap snapshot at 00:10
    ticks(10);
    check_disp("pre_lap", 8'h00, 8'h10);
    press(3'b001, 3);
    ticks(5);
    check("lap_active", {7'd0, lap_active}, 8'd1);
    check("lap_running", {7'd0, running}, 8'd1);
    check_disp("lap_frozen", 8'h00, 8'h10);
    press(3'b001, 3);
    check("unlap_active", {7'd0, lap_active}, 8'd0);
    check_disp("unlap_live", 8'h00, 8'h15);

    // Pause, ticks ignored, clear to idle
    press(3'b010, 3);
    check("pause_running", {7'd0, running}, 8'd0);
    ticks(3);
    check_disp("pause_hold", 8'h00, 8'h15);
    press(3'b100, 3);
    check_disp("clr_idle", 8'h00, 8'h00);

    // Clear ignored while running
    press(3'b010, 3);
    ticks(7);
    press(3'b100, 3);
    ticks(1);
    check_disp("clr_in_run", 8'h00, 8'h08);
    check("clr_in_run_running", {7'd0, running}, 8'd1);

    // All three at once in PAUSE: clear wins
    press(3'b010, 3);
    press(3'b111, 3);
    check_disp("all3", 8'h00, 8'h00);
    ticks(2);
    check("all3_idle", {7'd0, running}, 8'd0);
    check_disp("all3_idle", 8'h00, 8'h00);
    press(3'b001, 3);
    check("idle_lap_ignored", {7'd0, lap_active}, 8'd0);

    // Stop event coinciding with a tick still counts that tick
    press(3'b010, 3);
    ticks(4);
    btn_ss = 1'b1;
    tick   = 1'b1;
    step(3);
    tick   = 1'b0;
    btn_ss = 1'b0;
    step(3);
    check_disp("ss_tick", 8'h00, 8'h07);
    check("ss_tick_paused", {7'd0, running}, 8'd0);
    ticks(2);
    check_disp("ss_tick_hold", 8'h00, 8'h07);

    // Asynchronous reset mid-run at 00:42
    press(3'b010, 3);
    ticks(35);
    check_disp("pre_async", 8'h00, 8'h42);
    #2 rst = 1'b0;
    #1;
    check_disp("async", 8'h00, 8'h00);
    check("async_running", {7'd0, running}, 8'd0);
    #5 rst = 1'b1;
    step(2);
    ticks(3);
    check_disp("post_rst_idle", 8'h00, 8'h00);
    check("post_rst_running", {7'd0, running}, 8'd0);
    press(3'b010, 3);
    ticks(1);
    check_disp("post_rst_run", 8'h00, 8'h01);
    check("post_rst_running2", {7'd0, running}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Sequences the seconds/minutes BCD counting datapath of the board stopwatch from three push-button requests and a 1 Hz enable tick from the clock divider. Owns the run/pause/lap/clear state machine, the mod-60 BCD seconds and minutes registers, and a lap snapshot. Its display digits feed the existing seven-segment decoders (HEX0–HEX3) and its status bits drive LEDR.

Parameters:
SYNC_STAGES, 2, flip-flops in each button synchroniser (min 2)
SEC_LIMIT, 59, terminal value of seconds field (BCD tens ≤ 5)
MIN_LIMIT, 59, terminal value of minutes field

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst  input  1  asynchronous active-low reset
tick  input  1  one-cycle enable pulse at 1 Hz, synchronous to clk
btn_ss  input  1  start/stop request, level, asynchronous, active-high
btn_lap  input  1  lap request, level, asynchronous, active-high
btn_clr  input  1  clear request, level, asynchronous, active-high
disp_sec  output  8  displayed seconds, {tens, ones} BCD
disp_min  output  8  displayed minutes, {tens, ones} BCD
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
wrap  output  1  one-cycle pulse when 59:59 rolls to 00:00

Behaviour:
- Reset (rst low, async): state IDLE, all count and snapshot registers 0, all outputs 0, synchroniser and edge flops 0.
- Each button: SYNC_STAGES-FF synchroniser plus a rising-edge detector. With SYNC_STAGES=2, the internal event is a 1-cycle pulse on the 3rd clk edge after the input rises. Holding a button produces one event only.
- Priority when events coincide: clr > ss > lap. Lower-priority events in the same cycle are dropped.
- States and transitions (on internal events):
  - IDLE: ss -> RUN. lap and clr ignored.
  - RUN: ss -> PAUSE. lap -> LAP and captures live count into the snapshot. clr ignored.
  - LAP: lap -> RUN. ss -> PAUSE. clr ignored.
  - PAUSE: ss -> RUN. clr -> IDLE and zeroes counts and snapshot. lap ignored.
- Counting:
  - Counts advance on a cycle where the current (registered) state is RUN or LAP and tick=1, including the cycle in which an ss event leaves RUN. A tick in that cycle still counts.
  - A clr in the same cycle as a tick: clear wins, result is 00:00.
- Arithmetic, all in BCD, never binary:
  - sec ones 9 -> 0 with carry to sec tens.
  - sec = SEC_LIMIT -> 00 with carry into minutes.
  - min = MIN_LIMIT with carry -> 00.
  - wrap=1 in the cycle after the 59:59 -> 00:00 update (registered).
- Display: disp_* = snapshot in LAP, live count otherwise. All outputs registered; display updates 1 cycle after the count register changes.
- tick is not synchronised (same domain). tick held high for N cycles in RUN advances N seconds; no pulse stretching or filtering.

Decomposition:
- Shared package (stopwatch_pkg): state encoding localparams (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3) and BCD constants (BCD_NINE=4'd9, TENS_FIVE=4'd5).
- One natural sub-module: bcd_mod60_counter.
  - Inputs: clk, rst, en, clr. Outputs: tens[3:0], ones[3:0], carry_out.
  - Instantiated twice, for seconds and minutes. Minutes en = sec carry_out & en.

Test Plan:
- Reset then ss pulse (held 5 cycles), then 3 ticks -> running=1, disp_sec=8'h03, disp_min=8'h00; a single ss event despite 5-cycle hold.
- Preload via 59 ticks, then 1 more tick -> disp_sec=8'h00, disp_min=8'h01; then run to 59:59 and 1 tick -> 00:00 and wrap high exactly 1 cycle.
- In RUN at 00:10, lap then 5 ticks -> lap_active=1, disp_sec stays 8'h10; lap again -> disp_sec=8'h15 next cycle.
- In PAUSE at 00:07: ticks -> no change; clr -> IDLE, display 00:00. clr during RUN -> ignored, count keeps advancing.
- ss, lap and clr events in the same cycle while in PAUSE -> clr wins, IDLE; ss event in the same cycle as a tick in RUN -> count +1, then PAUSE.
- rst low asynchronously mid-RUN at 00:42 (not clock-aligned) -> all outputs 0 immediately; after rst release, stays IDLE until ss.
